// File: rtl/mem_req_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory controller: memop encoding, FSM state,
// and the memop-to-byte-count helper used by lane alignment and the misalign check.
package mem_req_ctrl_pkg;

  localparam int unsigned TmoCntW = 9;

  typedef enum logic [2:0] {
    MEM_NO = 3'd0,
    MEM_B  = 3'd1,
    MEM_H  = 3'd2,
    MEM_W  = 3'd3,
    MEM_D  = 3'd4,
    MEM_UB = 3'd5,
    MEM_UH = 3'd6,
    MEM_UW = 3'd7
  } memop_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } mem_state_t;

  function automatic logic [3:0] memop_bytes(logic [2:0] op);
    logic [3:0] nb;
    case (op)
      MEM_D:          nb = 4'd8;
      MEM_W, MEM_UW:  nb = 4'd4;
      MEM_H, MEM_UH:  nb = 4'd2;
      MEM_B, MEM_UB:  nb = 4'd1;
      default:        nb = 4'd0;
    endcase
    return nb;
  endfunction

  // Byte counts are powers of two, so the remainder is just the low offset bits.
  function automatic logic is_misaligned(logic [2:0] shift, logic [2:0] op);
    logic [3:0] nb;
    nb = memop_bytes(op);
    return (({1'b0, shift} & (nb - 4'd1)) != 4'd0);
  endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Data-memory bus: request (valid/ready with address, write data and byte mask)
// plus the read-response channel.
interface mem_req_ctrl_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  modport master (
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_lane_align.sv
// Places LSB-justified store data and its byte mask onto the lanes of the aligned
// 64-bit memory word.
module mem_lane_align
  import mem_req_ctrl_pkg::*;
(
  input  logic [2:0]  memop_i,
  input  logic [2:0]  shift_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  wmask_o
);

  always_comb begin
    wdata_o = wdata_i << {shift_i, 3'b000};
    // Lanes past byte 7 fall off when an access straddles the word.
    wmask_o = 8'(((16'd1 << memop_bytes(memop_i)) - 16'd1) << shift_i);
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// MEM-stage data-memory controller: latches one load/store, runs the request and
// response handshakes, stalls the pipeline meanwhile and retires with a one-cycle pulse.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned accesses without a request.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re_mem,
  input  logic                  we_mem,
  input  logic [63:0]           addr,
  input  logic [2:0]            memop,
  input  logic [63:0]           wdata,
  output logic                  stall,
  output logic                  rdata_valid,
  output logic [63:0]           rdata_raw,
  output logic [2:0]            shift,
  output logic [2:0]            memop_o,
  output logic                  err,
  mem_req_ctrl_if.master        mem
);

  localparam logic [TmoCntW-1:0] TmoLast = TmoCntW'(TIMEOUT_CYC - 1);

  mem_state_t         state_q, state_d;
  logic [63:0]        addr_q, addr_d;
  logic [63:0]        wdata_q, wdata_d;
  logic [63:0]        rdata_q, rdata_d;
  logic [2:0]         memop_q, memop_d;
  logic               store_q, store_d;
  logic               err_q, err_d;
  logic [TmoCntW-1:0] cnt_q, cnt_d;

  logic        accept, misalign, store_hs, load_hs, resp_hit, tmo_hit;
  logic [63:0] lane_wdata;
  logic [7:0]  lane_wmask;

  assign accept = (re_mem | we_mem) && (memop != MEM_NO);

`ifdef MISALIGN_TRAP_EN
  assign misalign = is_misaligned(addr[2:0], memop);
`else
  assign misalign = 1'b0;
`endif

  assign store_hs = (state_q == REQ) && mem.mem_req_ready && store_q;
  assign load_hs  = (state_q == REQ) && mem.mem_req_ready && !store_q;
  assign resp_hit = (state_q == WAIT) && mem.mem_resp_valid;
  // A completion landing on the last budget cycle wins over the abort.
  assign tmo_hit  = ((state_q == REQ) || (state_q == WAIT)) && (cnt_q == TmoLast) &&
                    !store_hs && !resp_hit;

  mem_lane_align u_lane_align (
    .memop_i (memop_q),
    .shift_i (addr_q[2:0]),
    .wdata_i (wdata_q),
    .wdata_o (lane_wdata),
    .wmask_o (lane_wmask)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      memop_q <= '0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      memop_q <= memop_d;
      store_q <= store_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = misalign ? DONE : REQ;
      REQ: begin
        if (store_hs || tmo_hit) state_d = DONE;
        else if (load_hs)        state_d = WAIT;
      end
      WAIT:    if (resp_hit || tmo_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    memop_d = memop_q;
    store_d = store_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if ((state_q == IDLE) && accept) begin
      addr_d  = addr;
      wdata_d = wdata;
      memop_d = memop;
      store_d = we_mem;
      rdata_d = '0;
      err_d   = misalign;
      cnt_d   = '0;
    end else if ((state_q == REQ) || (state_q == WAIT)) begin
      cnt_d = cnt_q + 1'b1;
      if (resp_hit) rdata_d = mem.mem_resp_data;
      if (tmo_hit)  err_d   = 1'b1;
    end
  end

  always_comb begin
    stall             = 1'b0;
    rdata_valid       = 1'b0;
    rdata_raw         = '0;
    shift             = '0;
    memop_o           = '0;
    err               = 1'b0;
    mem.mem_req_valid = 1'b0;
    mem.mem_addr      = '0;
    mem.mem_wen       = 1'b0;
    mem.mem_wdata     = '0;
    mem.mem_wmask     = '0;
    unique case (state_q)
      // Gated by reset so every output is quiet while reset is held.
      IDLE: stall = rst & (re_mem | we_mem);
      REQ: begin
        stall             = 1'b1;
        mem.mem_req_valid = 1'b1;
        mem.mem_addr      = {addr_q[63:3], 3'b000};
        mem.mem_wen       = store_q;
        mem.mem_wdata     = lane_wdata;
        mem.mem_wmask     = lane_wmask;
      end
      WAIT: stall = 1'b1;
      DONE: begin
        rdata_valid = 1'b1;
        rdata_raw   = rdata_q;
        shift       = addr_q[2:0];
        memop_o     = memop_q;
        err         = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: transaction-level model predicts each request and retire,
// a negedge compare process checks the DUT, directed cases pin literal values.
module tb_mem_req_ctrl;
  import mem_req_ctrl_pkg::*;

  localparam int Tmo = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        re_mem = 1'b0;
  logic        we_mem = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [2:0]  memop = '0;
  logic        stall, rdata_valid, err;
  logic [63:0] rdata_raw;
  logic [2:0]  shift, memop_o;

  mem_req_ctrl_if mif ();

  mem_req_ctrl #(.TIMEOUT_CYC(Tmo)) dut (
    .clk         (clk),
    .rst         (rst),
    .re_mem      (re_mem),
    .we_mem      (we_mem),
    .addr        (addr),
    .memop       (memop),
    .wdata       (wdata),
    .stall       (stall),
    .rdata_valid (rdata_valid),
    .rdata_raw   (rdata_raw),
    .shift       (shift),
    .memop_o     (memop_o),
    .err         (err),
    .mem         (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        issue;
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    logic [2:0]  shift;
    logic [2:0]  memop;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0;
  int   nerr = 0;
  int   n_retire = 0;
  int   lat, req_cyc, stall_cyc, base;

  logic [63:0] obs_addr, obs_wdata, obs_rdata;
  logic [7:0]  obs_wmask;
  logic [2:0]  obs_shift, obs_memop;
  logic        obs_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic int nbytes(logic [2:0] op);
    case (op)
      MEM_D:         return 8;
      MEM_W, MEM_UW: return 4;
      MEM_H, MEM_UH: return 2;
      MEM_B, MEM_UB: return 1;
      default:       return 0;
    endcase
  endfunction

  // What the access must look like on the bus and at retire, from the rules alone.
  function automatic exp_t model(logic st, logic [63:0] a, logic [2:0] op, logic [63:0] wd,
                                 logic [63:0] rsp, logic tmo);
    exp_t e;
    int   sh  = int'(a % 64'd8);
    int   nb  = nbytes(op);
    logic mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = (sh % nb) != 0;
`endif
    e.issue = !mis;
    e.addr  = a - 64'(sh);
    e.wen   = st;
    e.wdata = wd << (8 * sh);
    e.wmask = 8'(((1 << nb) - 1) << sh);
    e.err   = mis | tmo;
    e.rdata = (st || e.err) ? 64'd0 : rsp;
    e.shift = 3'(sh);
    e.memop = op;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (mif.mem_req_valid) begin
        if (exp_q.size() == 0 || !exp_q[0].issue) begin
          nchk++;
          nerr++;
          $display("FAIL req_valid: request issued while none expected");
        end else begin
          check("mem_addr", mif.mem_addr, exp_q[0].addr);
          check("mem_wen", 64'(mif.mem_wen), 64'(exp_q[0].wen));
          if (exp_q[0].wen) begin
            check("mem_wdata", mif.mem_wdata, exp_q[0].wdata);
            check("mem_wmask", 64'(mif.mem_wmask), 64'(exp_q[0].wmask));
          end
        end
      end
      if (rdata_valid) begin
        if (exp_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL retire: rdata_valid with no access outstanding");
        end else begin
          check("rdata_raw", rdata_raw, exp_q[0].rdata);
          check("shift", 64'(shift), 64'(exp_q[0].shift));
          check("memop_o", 64'(memop_o), 64'(exp_q[0].memop));
          check("err", 64'(err), 64'(exp_q[0].err));
          check("stall_done", 64'(stall), 64'd0);
          void'(exp_q.pop_front());
        end
        n_retire++;
      end
    end
  end

  // Issues one access and plays memory: ready after rdy_dly request cycles (-1 never),
  // response rsp_dly cycles after the handshake (-1 never).
  task automatic access(input string name, input logic st, input logic [63:0] a,
                        input logic [2:0] op, input logic [63:0] wd, input int rdy_dly,
                        input int rsp_dly, input logic [63:0] rsp, input logic tmo,
                        input logic hold);
    int hs = -1;
    exp_q.push_back(model(st, a, op, wd, rsp, tmo));
    @(posedge clk); #1;
    re_mem = !st; we_mem = st; addr = a; memop = op; wdata = wd;
    mif.mem_req_ready = 1'b0; mif.mem_resp_valid = 1'b0; mif.mem_resp_data = rsp;
    lat = -1; req_cyc = 0; stall_cyc = 0;
    for (int c = 0; c < Tmo + 20; c++) begin
      @(negedge clk);
      mif.mem_resp_valid = (hs >= 0) && (rsp_dly >= 0) && (c == hs + rsp_dly);
      mif.mem_req_ready  = 1'b0;
      if (mif.mem_req_valid) begin
        if (req_cyc == 0) begin
          obs_addr = mif.mem_addr; obs_wdata = mif.mem_wdata; obs_wmask = mif.mem_wmask;
        end
        if (rdy_dly >= 0 && req_cyc >= rdy_dly) begin
          mif.mem_req_ready = 1'b1;
          hs = c;
        end
        req_cyc++;
      end
      if (stall) stall_cyc++;
      if (rdata_valid) begin
        lat = c;
        obs_rdata = rdata_raw; obs_shift = shift; obs_memop = memop_o; obs_err = err;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      nchk++;
      nerr++;
      $display("FAIL %s: no retire within %0d cycles", name, Tmo + 20);
    end
    if (!hold) begin
      @(posedge clk); #1;
      re_mem = 1'b0; we_mem = 1'b0;
      mif.mem_req_ready = 1'b0; mif.mem_resp_valid = 1'b0;
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_ctl"}, {59'd0, stall, rdata_valid, err, mif.mem_req_valid, mif.mem_wen},
          64'd0);
    check({name, "_data"}, rdata_raw | mif.mem_addr | mif.mem_wdata, 64'd0);
    check({name, "_small"}, {50'd0, shift, memop_o, mif.mem_wmask}, 64'd0);
  endtask

  initial begin
    mif.mem_req_ready = 1'b0; mif.mem_resp_valid = 1'b0; mif.mem_resp_data = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1 rst = 1'b1;

    access("ld_h", 1'b0, 64'h1006, MEM_H, 64'd0, 0, 1, 64'h8899_AABB_CCDD_EEFF, 1'b0, 1'b0);
    check("ld_lat", 64'(lat), 64'd3);
    check("ld_stall_cycles", 64'(stall_cyc), 64'd3);
    check("ld_addr_lit", obs_addr, 64'h1000);
    check("ld_rdata_lit", obs_rdata, 64'h8899_AABB_CCDD_EEFF);
    check("ld_shift_lit", 64'(obs_shift), 64'd6);
    check("ld_memop_lit", 64'(obs_memop), 64'(MEM_H));

    access("sd_b", 1'b1, 64'h2003, MEM_B, 64'h5A, 4, -1, 64'd0, 1'b0, 1'b0);
    check("sd_req_cycles", 64'(req_cyc), 64'd5);
    check("sd_wdata_lit", obs_wdata, 64'h5A00_0000);
    check("sd_wmask_lit", 64'(obs_wmask), 64'h08);
    check("sd_lat", 64'(lat), 64'd6);

    access("sd_d", 1'b1, 64'h5000, MEM_D, 64'h0123_4567_89AB_CDEF, 1, -1, 64'd0, 1'b0, 1'b0);
    check("sd_d_wmask_lit", 64'(obs_wmask), 64'hFF);
    access("ld_uw", 1'b0, 64'h6004, MEM_UW, 64'd0, 2, 3, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0);
    check("ld_uw_lat", 64'(lat), 64'd7);
    access("sd_h", 1'b1, 64'h6002, MEM_H, 64'hBEEF, 0, -1, 64'd0, 1'b0, 1'b0);
    check("sd_h_wmask_lit", 64'(obs_wmask), 64'h0C);
    check("sd_h_lat", 64'(lat), 64'd2);

    access("tmo", 1'b0, 64'h4000, MEM_D, 64'd0, -1, -1, 64'd0, 1'b1, 1'b0);
    check("tmo_lat", 64'(lat), 64'(Tmo + 1));
    check("tmo_req_cycles", 64'(req_cyc), 64'(Tmo));
    check("tmo_err_lit", 64'(obs_err), 64'd1);
    check("tmo_rdata_lit", obs_rdata, 64'd0);
    base = n_retire;
    mif.mem_resp_valid = 1'b1; mif.mem_resp_data = 64'h5555;
    @(posedge clk); #1 mif.mem_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("tmo_stale_resp", 64'(n_retire - base), 64'd0);

    exp_q.push_back(model(1'b0, 64'h8000, MEM_D, 64'd0, 64'd0, 1'b0));
    @(posedge clk); #1;
    re_mem = 1'b1; addr = 64'h8000; memop = MEM_D; mif.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mif.mem_req_ready = 1'b0;
    check("wait_stall", 64'(stall), 64'd1);
    #2 rst = 1'b0;
    #1 check_quiet("rst_mid_wait");
    re_mem = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    base = n_retire;
    mif.mem_resp_valid = 1'b1; mif.mem_resp_data = 64'hBAD0_BAD0;
    @(posedge clk); #1 mif.mem_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_stale_resp", 64'(n_retire - base), 64'd0);
    access("rst_new", 1'b0, 64'h8010, MEM_W, 64'd0, 0, 1, 64'h0000_0001_7777_8888, 1'b0, 1'b0);
    check("rst_new_lat", 64'(lat), 64'd3);
    check("rst_new_rdata_lit", obs_rdata, 64'h0000_0001_7777_8888);

    base = n_retire;
    access("b2b_a", 1'b0, 64'h7008, MEM_W, 64'd0, 0, 1, 64'hAAAA_5555_0000_FFFF, 1'b0, 1'b1);
    check("b2b_a_lat", 64'(lat), 64'd3);
    access("b2b_b", 1'b0, 64'h7012, MEM_UH, 64'd0, 0, 1, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
    check("b2b_b_lat", 64'(lat), 64'd3);
    check("b2b_b_shift_lit", 64'(obs_shift), 64'd2);
    repeat (2) @(negedge clk);
    check("b2b_retires", 64'(n_retire - base), 64'd2);

    access("mis_w", 1'b1, 64'h3006, MEM_W, 64'h1122_3344, 0, -1, 64'd0, 1'b0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    check("mis_lat", 64'(lat), 64'd1);
    check("mis_no_req", 64'(req_cyc), 64'd0);
    check("mis_err_lit", 64'(obs_err), 64'd1);
`else
    check("mis_lat", 64'(lat), 64'd2);
    check("mis_wmask_lit", 64'(obs_wmask), 64'hC0);
    check("mis_wdata_lit", obs_wdata, 64'h3344_0000_0000_0000);
    check("mis_err_lit", 64'(obs_err), 64'd0);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
